// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO sequencer: R-type functs, FSM encodings
// and funct-class helpers.
package muldiv_pkg;

  localparam logic [4:0] ALU_RTYPE = 5'b01111;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MUL_BUSY  = 3'd1;
  localparam logic [2:0] ST_DIV_BUSY  = 3'd2;
  localparam logic [2:0] ST_DRAIN_MUL = 3'd3;
  localparam logic [2:0] ST_DRAIN_DIV = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_MUL_BUSY  = ST_MUL_BUSY,
    S_DIV_BUSY  = ST_DIV_BUSY,
    S_DRAIN_MUL = ST_DRAIN_MUL,
    S_DRAIN_DIV = ST_DRAIN_DIV
  } muldiv_state_t;

  // MULT/MULTU/DIV/DIVU all share the 0110xx prefix.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

  // MFHI/MTHI/MFLO/MTLO all share the 0100xx prefix.
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0100);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the multi-cycle Mult/Div units: launches a unit,
// stalls the pipe until it finishes, and owns the architectural HI/LO pair.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter bit DIV_ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        mul_start,
  output logic        div_start,
  output logic        mul_sign,
  output logic        div_sign,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic        mul_start_reg;
  logic        div_start_reg;
  logic        mul_sign_reg;
  logic        div_sign_reg;
  logic [31:0] unit_a_reg;
  logic [31:0] unit_b_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        muldiv_op;
  logic        hilo_op;
  logic        is_div;
  logic        is_signed;
  logic        zero_skip;
  logic        in_idle;
  logic        in_busy;
  logic        in_drain;
  logic        busy_done;
  logic        accept;
  logic        result_write;
  logic        mt_ok;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  // Decode: bit 1 selects the divider, bit 0 selects the unsigned variant.
  assign muldiv_op = op_valid & is_muldiv_funct(funct);
  assign hilo_op   = op_valid & is_hilo_funct(funct);
  assign is_div    = funct[1];
  assign is_signed = ~funct[0];
  assign zero_skip = DIV_ZERO_SKIP && is_div && (src_b == 32'd0);

  assign in_idle   = (state_reg == ST_IDLE);
  assign in_busy   = (state_reg == ST_MUL_BUSY) | (state_reg == ST_DIV_BUSY);
  assign in_drain  = (state_reg == ST_DRAIN_MUL) | (state_reg == ST_DRAIN_DIV);
  assign busy_done = ((state_reg == ST_MUL_BUSY) & mul_done) |
                     ((state_reg == ST_DIV_BUSY) & div_done);

  assign accept       = in_idle & muldiv_op & ~flush & ~zero_skip;
  assign result_write = busy_done & ~flush;
  assign mt_ok        = in_idle & op_valid & ~flush;

  assign result_hi = (state_reg == ST_MUL_BUSY) ? mul_hi : div_hi;
  assign result_lo = (state_reg == ST_MUL_BUSY) ? mul_lo : div_lo;

  // The issuing instruction is held from accept until its done cycle; during a
  // drain only instructions touching the units or HI/LO have to wait.
  assign stall = accept
               | (in_busy & ~busy_done & ~flush)
               | (in_drain & (muldiv_op | hilo_op));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_div ? ST_DIV_BUSY : ST_MUL_BUSY;
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_next = ST_IDLE;
        end else if (flush) begin
          state_next = ST_DRAIN_MUL;
        end
      end
      ST_DIV_BUSY: begin
        if (div_done) begin
          state_next = ST_IDLE;
        end else if (flush) begin
          state_next = ST_DRAIN_DIV;
        end
      end
      ST_DRAIN_MUL: begin
        if (mul_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN_DIV: begin
        if (div_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Start pulses are one cycle wide by construction: accept only fires in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start_reg <= 1'b0;
      div_start_reg <= 1'b0;
    end else begin
      mul_start_reg <= accept & ~is_div;
      div_start_reg <= accept & is_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_a_reg   <= 32'd0;
      unit_b_reg   <= 32'd0;
      mul_sign_reg <= 1'b0;
      div_sign_reg <= 1'b0;
    end else if (accept) begin
      unit_a_reg <= src_a;
      unit_b_reg <= src_b;
      if (is_div) begin
        div_sign_reg <= is_signed;
      end else begin
        mul_sign_reg <= is_signed;
      end
    end
  end

  // Result writes and MTHI/MTLO are mutually exclusive: an MT cannot reach
  // execute while a unit is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (result_write) begin
      hi_reg <= result_hi;
      lo_reg <= result_lo;
    end else if (mt_ok) begin
      if (funct == FUNCT_MTHI) begin
        hi_reg <= src_a;
      end
      if (funct == FUNCT_MTLO) begin
        lo_reg <= src_a;
      end
    end
  end

  assign mul_start = mul_start_reg;
  assign div_start = div_start_reg;
  assign mul_sign  = mul_sign_reg;
  assign div_sign  = div_sign_reg;
  assign unit_a    = unit_a_reg;
  assign unit_b    = unit_b_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule
